// File: rtl/hazard_unit.sv
// Load-use / ID-branch hazard stall and taken-branch flush control; outputs combinational, zero latency.
// Stalls hold PC and IF/ID and bubble ID/EX; optional saturating stall/flush counters under HAZARD_STATS_EN.
module hazard_unit #(
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        ID_Rs,
   input  logic [4:0]        ID_Rt,
   input  logic              ID_UsesRt,
   input  logic              ID_Branch,
   input  logic              ID_Jump,
   input  logic              BranchTaken,
   input  logic              ID_EX_MemRead,
   input  logic              ID_EX_RegWrite,
   input  logic [4:0]        ID_EX_Dst,
   input  logic              EX_MEM_MemRead,
   input  logic [4:0]        EX_MEM_Dst,
   output logic              PCWrite,
   output logic              IF_ID_Write,
   output logic              ID_EX_Bubble,
   output logic              IF_ID_Flush,
   output logic [STAT_W-1:0] StallCycles,
   output logic [STAT_W-1:0] FlushCount
);

   typedef enum logic {RUN, STALL} state_t;

   state_t     state;
   logic [1:0] cnt;
   logic [1:0] need;
   logic       stall;
   logic       flush;

   function automatic logic hit(input logic [4:0] dst, input logic [4:0] rs,
                                input logic [4:0] rt, input logic uses_rt);
      return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
   endfunction

   logic ex_hit;
   logic mem_hit;

   always_comb begin
      ex_hit  = hit(ID_EX_Dst, ID_Rs, ID_Rt, ID_UsesRt);
      mem_hit = hit(EX_MEM_Dst, ID_Rs, ID_Rt, ID_UsesRt);
      need    = 2'd0;
      if (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && ex_hit)
         need = 2'd1;
      if (ID_Branch && EX_MEM_MemRead && mem_hit)
         need = 2'd1;
      // A branch consuming a load still in EX must wait for both EX and MEM to drain.
      if (ID_EX_MemRead && ex_hit)
         need = ID_Branch ? 2'd2 : 2'd1;
   end

   always_comb begin
      stall = 1'b0;
      flush = 1'b0;
      if (rst_n) begin
         if (state == STALL) begin
            stall = 1'b1;
         end else if (need != 2'd0) begin
            stall = 1'b1;
         end else begin
            flush = (ID_Branch && BranchTaken) || ID_Jump;
         end
      end
   end

   assign PCWrite      = !stall;
   assign IF_ID_Write  = !stall;
   assign ID_EX_Bubble = stall;
   assign IF_ID_Flush  = flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         case (state)
            RUN: begin
               if (need == 2'd2) begin
                  state <= STALL;
                  cnt   <= 2'd1;
               end
            end
            STALL: begin
               cnt <= cnt - 2'd1;
               if (cnt == 2'd1)
                  state <= RUN;
            end
            default: begin
               state <= RUN;
               cnt   <= 2'd0;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [STAT_W-1:0] stall_q;
   logic [STAT_W-1:0] flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall && (stall_q != STAT_MAX))
            stall_q <= stall_q + 1'b1;
         if (flush && (flush_q != STAT_MAX))
            flush_q <= flush_q + 1'b1;
      end
   end

   assign StallCycles = stall_q;
   assign FlushCount  = flush_q;
`else
   assign StallCycles = '0;
   assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized + directed bench for hazard_unit against a remaining-stall-count reference model.
module tb_hazard_unit;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int SW      = 4;
   localparam int SAT_MAX = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [4:0]    ID_Rs = '0, ID_Rt = '0, ID_EX_Dst = '0, EX_MEM_Dst = '0;
   logic          ID_UsesRt = 0, ID_Branch = 0, ID_Jump = 0, BranchTaken = 0;
   logic          ID_EX_MemRead = 0, ID_EX_RegWrite = 0, EX_MEM_MemRead = 0;
   logic          PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
   logic [SW-1:0] StallCycles, FlushCount;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_left   = 0;
   int m_stalls = 0;
   int m_flush  = 0;

   hazard_unit #(.STAT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .BranchTaken(BranchTaken),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Dst(ID_EX_Dst),
      .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Dst(EX_MEM_Dst),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
      .IF_ID_Flush(IF_ID_Flush), .StallCycles(StallCycles), .FlushCount(FlushCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit dep(input logic [4:0] d);
      return d != 0 && (d == ID_Rs || (ID_UsesRt && d == ID_Rt));
   endfunction

   // Stall length the ID instruction requires, from the hazard rules.
   function automatic int need_now();
      int n = 0;
      if (ID_EX_MemRead && dep(ID_EX_Dst)) n = ID_Branch ? 2 : 1;
      if (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && dep(ID_EX_Dst) && n < 1) n = 1;
      if (ID_Branch && EX_MEM_MemRead && dep(EX_MEM_Dst) && n < 1) n = 1;
      return n;
   endfunction

   task automatic check_outs(input string tag, input bit e_stall, input bit e_flush);
      chk({tag, "_pc"},    32'(PCWrite),      32'(!e_stall));
      chk({tag, "_ifid"},  32'(IF_ID_Write),  32'(!e_stall));
      chk({tag, "_bub"},   32'(ID_EX_Bubble), 32'(e_stall));
      chk({tag, "_flush"}, 32'(IF_ID_Flush),  32'(e_flush));
      chk({tag, "_scnt"},  32'(StallCycles),  STATS ? 32'(m_stalls) : 32'd0);
      chk({tag, "_fcnt"},  32'(FlushCount),   STATS ? 32'(m_flush) : 32'd0);
   endtask

   // One clock cycle with the current inputs: check mid-cycle, then advance the model.
   task automatic step(input string tag);
      int n = 0;
      bit e_stall = 0, e_flush = 0;
      @(negedge clk);
      if (rst_n) begin
         if (m_left > 0) e_stall = 1;
         else begin
            n       = need_now();
            e_stall = n > 0;
            e_flush = n == 0 && ((ID_Branch && BranchTaken) || ID_Jump);
         end
      end
      check_outs(tag, e_stall, e_flush);
      @(posedge clk);
      if (rst_n) begin
         if (m_left > 0) m_left--;
         else if (n == 2) m_left = 1;
         if (e_stall && m_stalls < SAT_MAX) m_stalls++;
         if (e_flush && m_flush < SAT_MAX) m_flush++;
      end
      #1;
   endtask

   task automatic idle_inputs();
      ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_Branch = 0; ID_Jump = 0; BranchTaken = 0;
      ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_Dst = 0; EX_MEM_MemRead = 0; EX_MEM_Dst = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      m_left = 0; m_stalls = 0; m_flush = 0;
      #1;
      check_outs("rst", 0, 0);
      step("rst_hold");
      rst_n = 1;
   endtask

   initial begin
      idle_inputs();
      #2;
      apply_reset();

      // branch on load in EX: two stalls, second cycle ignores its inputs
      ID_Branch = 1; BranchTaken = 1; ID_EX_MemRead = 1; ID_EX_RegWrite = 1;
      ID_EX_Dst = 9; ID_Rt = 9; ID_UsesRt = 1; ID_Rs = 3;
      step("brld1");
      idle_inputs(); ID_Jump = 1;
      step("brld2");
      chk("brld_cnt", 32'(StallCycles), STATS ? 32'd2 : 32'd0);
      idle_inputs();
      step("brld_done");

      // load-use then bubble
      ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Dst = 8; ID_Rs = 8;
      step("lu");
      ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_Dst = 0;
      step("lu_after");

      // $zero and unused-rt immunity
      ID_EX_MemRead = 1; ID_EX_Dst = 0; ID_Rs = 0;
      step("zero");
      ID_EX_Dst = 5; ID_Rt = 5; ID_Rs = 1; ID_UsesRt = 0;
      step("no_rt");

      // taken branch, jump, and branch delayed by an ALU dependency
      idle_inputs(); ID_Branch = 1; BranchTaken = 1;
      step("taken");
      idle_inputs(); ID_Jump = 1;
      step("jump");
      idle_inputs(); ID_Branch = 1; BranchTaken = 1; ID_EX_RegWrite = 1; ID_EX_Dst = 4; ID_Rs = 4;
      step("br_alu");
      ID_EX_RegWrite = 0; ID_EX_Dst = 0;
      step("br_alu_go");
      idle_inputs(); ID_Branch = 1; EX_MEM_MemRead = 1; EX_MEM_Dst = 6; ID_Rs = 6;
      step("br_mem");

      // reset in the second cycle of a two-cycle stall
      idle_inputs(); ID_Branch = 1; ID_EX_MemRead = 1; ID_EX_Dst = 9; ID_Rs = 9;
      step("rs_mid1");
      apply_reset();
      step("rs_mid_after");
      idle_inputs();
      step("rs_mid_idle");

      // saturation of the stall counter
      ID_EX_MemRead = 1; ID_EX_Dst = 7; ID_Rs = 7;
      for (int i = 0; i < 20; i++) step("sat");
      chk("sat_cnt", 32'(StallCycles), STATS ? 32'(SAT_MAX) : 32'd0);

      // random traffic over a small register range to force frequent matches
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         ID_Rs          = 5'($urandom_range(0, 3));
         ID_Rt          = 5'($urandom_range(0, 3));
         ID_UsesRt      = 1'($urandom);
         ID_Branch      = ($urandom_range(0, 2) == 0);
         BranchTaken    = 1'($urandom);
         ID_Jump        = ($urandom_range(0, 5) == 0);
         ID_EX_MemRead  = 1'($urandom);
         ID_EX_RegWrite = 1'($urandom);
         ID_EX_Dst      = 5'($urandom_range(0, 3));
         EX_MEM_MemRead = 1'($urandom);
         EX_MEM_Dst     = 5'($urandom_range(0, 3));
         if (i % 97 == 50) apply_reset();
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
